pipe_stage_hs: RTL and testbench

Parametrised, handshaked pipeline-stage register generalising the fixed MEM/WB-style stage registers of the RV32I vector core. It carries a control word, destination register address and a multi-lane data bus between any two pipeline stages with valid/ready flow control, a 2-entry skid buffer for full throughput with registered `in_ready`, synchronous flush (bubble insertion), per-lane write masking and a saturating back-pressure counter.

---
 rtl/pipe_pkg.sv | 47 ++++
 rtl/pipe_entry_reg.sv | 72 +++++++
 rtl/pipe_stage_hs.sv | 164 ++++++++++++++++
 tb/tb_pipe_stage_hs.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and helpers for the handshaked pipeline stage.
//               Holds the occupancy state encoding and the lane-masking
//               function used when an entry is captured.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Upper bounds for the width-generic lane-mask helper. Callers zero-extend
  // into these widths and truncate the result back to their own bus width.
  localparam int c_MAX_LANES  = 32;
  localparam int c_MAX_DATA_W = 1024;

  // Occupancy of the two-entry stage: nothing held, MAIN only, MAIN and SKID.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Zero every lane whose mask bit is clear; lanes at or beyond `lanes` are
  // also zeroed so the caller can truncate without stray bits.
  function automatic logic [c_MAX_DATA_W-1:0] mask_lanes(
    input logic [c_MAX_DATA_W-1:0] data,
    input logic [c_MAX_LANES-1:0]  mask,
    input int                      lanes,
    input int                      lane_w
  );
    logic [c_MAX_DATA_W-1:0] lane_ones;
    logic [c_MAX_DATA_W-1:0] result;
    logic [c_MAX_LANES-1:0]  mask_sh;
    lane_ones = ({{(c_MAX_DATA_W-1){1'b0}}, 1'b1} << lane_w)
              - {{(c_MAX_DATA_W-1){1'b0}}, 1'b1};
    result    = data;
    for (int l = 0; l < c_MAX_LANES; l++) begin
      mask_sh = mask >> l;
      if ((l >= lanes) || !mask_sh[0]) begin
        result = result & ~(lane_ones << (l * lane_w));
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_entry_reg
// Description : One storage entry of the pipeline stage (control word,
//               destination register, lane-masked data, lane mask). Data is
//               masked on capture; clear kills the control fields only.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 40,
  parameter int ADDR_W = 6,
  parameter int LANES  = 4,
  parameter int LANE_W = 32
) (
  input  logic                    clock,
  input  logic                    async_reset,
  input  logic                    load,
  input  logic                    clear,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [ADDR_W-1:0]       in_rd,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [LANES-1:0]        in_mask,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [ADDR_W-1:0]       out_rd,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [LANES-1:0]        out_mask
);

  localparam int c_DATA_W = LANES * LANE_W;

  logic [CTRL_W-1:0]   r_ctrl;
  logic [ADDR_W-1:0]   r_rd;
  logic [c_DATA_W-1:0] r_data;
  logic [LANES-1:0]    r_mask;
  logic [c_DATA_W-1:0] w_data_masked;

  // Lanes with a clear mask bit are stored as zero.
  always_comb begin
    w_data_masked = c_DATA_W'(mask_lanes(c_MAX_DATA_W'(in_data),
                                         c_MAX_LANES'(in_mask),
                                         LANES, LANE_W));
  end

  // Clear beats load so a kill in the same cycle as a capture wins; data is
  // left in place on clear since it is meaningless once the entry is invalid.
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_ctrl <= '0;
      r_rd   <= '0;
      r_data <= '0;
      r_mask <= '0;
    end else if (clear) begin
      r_ctrl <= '0;
      r_rd   <= '0;
      r_mask <= '0;
    end else if (load) begin
      r_ctrl <= in_ctrl;
      r_rd   <= in_rd;
      r_data <= w_data_masked;
      r_mask <= in_mask;
    end
  end

  assign out_ctrl = r_ctrl;
  assign out_rd   = r_rd;
  assign out_data = r_data;
  assign out_mask = r_mask;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_hs
// Description : Parametrised valid/ready pipeline-stage register with a
//               two-entry skid buffer (registered in_ready), synchronous
//               flush, per-lane write masking and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 40,
  parameter int ADDR_W = 6,
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clock,
  input  logic                    async_reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [ADDR_W-1:0]       in_rd,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [LANES-1:0]        in_mask,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [ADDR_W-1:0]       out_rd,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [LANES-1:0]        out_mask,
  output logic [CNT_W-1:0]        stall_count
);

  localparam int c_DATA_W = LANES * LANE_W;

  pipe_state_t         r_state;
  pipe_state_t         w_state_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_stall_count;

  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_main_load;
  logic                w_main_from_skid;
  logic                w_skid_load;

  logic [CTRL_W-1:0]   w_skid_ctrl;
  logic [ADDR_W-1:0]   w_skid_rd;
  logic [c_DATA_W-1:0] w_skid_data;
  logic [LANES-1:0]    w_skid_mask;

  logic [CTRL_W-1:0]   w_main_ctrl_d;
  logic [ADDR_W-1:0]   w_main_rd_d;
  logic [c_DATA_W-1:0] w_main_data_d;
  logic [LANES-1:0]    w_main_mask_d;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // Occupancy transitions; flush overrides everything and empties the stage.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_in_fire) w_state_nxt = ONE;
        ONE: begin
          if (w_in_fire && !w_out_fire)      w_state_nxt = FULL;
          else if (!w_in_fire && w_out_fire) w_state_nxt = EMPTY;
        end
        FULL:    if (w_out_fire) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // MAIN refills from SKID when draining FULL, otherwise from the input;
  // SKID only captures when an input arrives while MAIN is stuck.
  always_comb begin
    w_main_from_skid = (r_state == FULL);
    w_main_load      = !flush &&
                       (((r_state == EMPTY) && w_in_fire) ||
                        ((r_state == ONE) && w_in_fire && w_out_fire) ||
                        ((r_state == FULL) && w_out_fire));
    w_skid_load      = !flush && (r_state == ONE) && w_in_fire && !w_out_fire;
    w_main_ctrl_d    = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    w_main_rd_d      = w_main_from_skid ? w_skid_rd   : in_rd;
    w_main_data_d    = w_main_from_skid ? w_skid_data : in_data;
    w_main_mask_d    = w_main_from_skid ? w_skid_mask : in_mask;
  end

  // State plus registered handshake outputs, all derived from the next state
  // so in_ready never sees out_ready combinationally.
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

  // Count cycles the downstream refuses a valid entry, saturating at all-ones.
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_stall_count <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .ADDR_W (ADDR_W),
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_main (
    .clock       (clock),
    .async_reset (async_reset),
    .load        (w_main_load),
    .clear       (flush),
    .in_ctrl     (w_main_ctrl_d),
    .in_rd       (w_main_rd_d),
    .in_data     (w_main_data_d),
    .in_mask     (w_main_mask_d),
    .out_ctrl    (out_ctrl),
    .out_rd      (out_rd),
    .out_data    (out_data),
    .out_mask    (out_mask)
  );

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .ADDR_W (ADDR_W),
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_skid (
    .clock       (clock),
    .async_reset (async_reset),
    .load        (w_skid_load),
    .clear       (flush),
    .in_ctrl     (in_ctrl),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .in_mask     (in_mask),
    .out_ctrl    (w_skid_ctrl),
    .out_rd      (w_skid_rd),
    .out_data    (w_skid_data),
    .out_mask    (w_skid_mask)
  );

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_hs
// Description : Self-checking bench for pipe_stage_hs. A queue-based model of
//               a two-deep FIFO stage predicts every output after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;

  localparam int CTRL_W = 40;
  localparam int ADDR_W = 6;
  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int CNT_W  = 4;
  localparam int W      = LANES * LANE_W;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              async_reset;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [ADDR_W-1:0] in_rd;
  logic [W-1:0]      in_data;
  logic [LANES-1:0]  in_mask;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [ADDR_W-1:0] out_rd;
  logic [W-1:0]      out_data;
  logic [LANES-1:0]  out_mask;
  logic [CNT_W-1:0]  stall_count;

  always #5 clock = ~clock;

  pipe_stage_hs #(
    .CTRL_W (CTRL_W),
    .ADDR_W (ADDR_W),
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock       (clock),
    .async_reset (async_reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .in_mask     (in_mask),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_rd      (out_rd),
    .out_data    (out_data),
    .out_mask    (out_mask),
    .stall_count (stall_count)
  );

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] rd;
    logic [W-1:0]      data;
    logic [LANES-1:0]  mask;
  } ent_t;

  ent_t q[$];
  bit   exp_ready;
  int   exp_stall;
  int   passed = 0;
  int   total  = 0;

  function automatic logic [W-1:0] apply_mask(input logic [W-1:0] d, input logic [LANES-1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (m[i]) r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    q.delete();
    exp_ready = 1'b1;
    exp_stall = 0;
  endtask

  // Stage as a FIFO of depth two: accept only when the previous edge left
  // fewer than two entries, flush discards everything including the offer.
  task automatic model_edge();
    bit   in_fire;
    bit   out_fire;
    ent_t e;
    if ((q.size() > 0) && !out_ready && (exp_stall < SAT)) exp_stall++;
    in_fire  = in_valid && exp_ready;
    out_fire = (q.size() > 0) && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) begin
        e.ctrl = in_ctrl;
        e.rd   = in_rd;
        e.data = apply_mask(in_data, in_mask);
        e.mask = in_mask;
        q.push_back(e);
      end
    end
    exp_ready = (q.size() < 2);
  endtask

  task automatic check_all();
    chk("out_valid", W'(out_valid), W'(q.size() > 0));
    chk("in_ready", W'(in_ready), W'(exp_ready));
    chk("stall_count", W'(stall_count), W'(exp_stall));
    if (q.size() > 0) begin
      chk("out_ctrl", W'(out_ctrl), W'(q[0].ctrl));
      chk("out_rd", W'(out_rd), W'(q[0].rd));
      chk("out_data", out_data, q[0].data);
      chk("out_mask", W'(out_mask), W'(q[0].mask));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic offer(input bit v);
    in_valid = v;
    in_ctrl  = {8'($urandom()), $urandom()};
    in_rd    = 6'($urandom());
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_mask  = 4'($urandom());
  endtask

  initial begin
    async_reset = 1'b0;
    in_valid    = 1'b0;
    in_ctrl     = '0;
    in_rd       = '0;
    in_data     = '0;
    in_mask     = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_ctrl", W'(out_ctrl), W'(0));
    chk("rst_out_rd", W'(out_rd), W'(0));
    chk("rst_out_data", out_data, W'(0));
    chk("rst_out_mask", W'(out_mask), W'(0));
    chk("rst_stall", W'(stall_count), W'(0));
    async_reset = 1'b1;

    // Full-rate stream.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1);
      tick();
      chk("stream_in_ready", W'(in_ready), W'(1));
    end
    offer(1'b0);
    repeat (2) tick();
    chk("stream_stall", W'(stall_count), W'(0));

    // Three cycles of back-pressure mid-stream.
    for (int i = 0; i < 3; i++) begin
      offer(1'b1);
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1);
      tick();
      chk("bp_in_ready_low", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1);
      tick();
    end
    offer(1'b0);
    repeat (3) tick();
    chk("bp_stall_3", W'(stall_count), W'(3));

    // Lane masking.
    in_valid = 1'b1;
    in_data  = {4{32'hDEADBEEF}};
    in_mask  = 4'b0101;
    tick();
    chk("mask_data", out_data, 128'h00000000_DEADBEEF_00000000_DEADBEEF);
    chk("mask_mask", W'(out_mask), W'(4'b0101));
    in_valid = 1'b0;
    tick();

    // Flush while FULL.
    out_ready = 1'b0;
    offer(1'b1);
    tick();
    offer(1'b1);
    tick();
    chk("full_in_ready", W'(in_ready), W'(0));
    offer(1'b1);
    flush = 1'b1;
    tick();
    chk("flush_out_valid", W'(out_valid), W'(0));
    chk("flush_out_ctrl", W'(out_ctrl), W'(0));
    chk("flush_in_ready", W'(in_ready), W'(1));
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();

    // Flush while ONE with an acceptable offer: the offer is dropped.
    offer(1'b1);
    tick();
    offer(1'b1);
    flush = 1'b1;
    tick();
    chk("flush1_out_valid", W'(out_valid), W'(0));
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();

    // Counter saturation.
    out_ready = 1'b0;
    offer(1'b1);
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("stall_sat", W'(stall_count), W'(SAT));
    out_ready = 1'b1;
    tick();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      offer(bit'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    offer(1'b1);
    tick();
    offer(1'b1);
    tick();
    chk("pre_rst_in_ready", W'(in_ready), W'(0));
    in_valid = 1'b0;
    #2;
    async_reset = 1'b0;
    #1;
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_in_ready", W'(in_ready), W'(1));
    chk("arst_out_ctrl", W'(out_ctrl), W'(0));
    chk("arst_out_rd", W'(out_rd), W'(0));
    chk("arst_out_data", out_data, W'(0));
    chk("arst_out_mask", W'(out_mask), W'(0));
    chk("arst_stall", W'(stall_count), W'(0));
    model_reset();
    #1;
    async_reset = 1'b1;
    tick();
    out_ready = 1'b1;
    offer(1'b1);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
